// File: rtl/pf_pkg.sv
// pf_pkg -- shared single-precision float definitions.
//
// Used by int_to_pf and pf_round (and later by the float adder's
// normaliser). It provides the exponent/fraction widths, the exponent bias,
// a packed IEEE-754 single struct, and the converter FSM state enum.
package pf_pkg;

  localparam int PF_EXP_W  = 8;
  localparam int PF_FRAC_W = 23;
  localparam int PF_BIAS   = 127;

  // Field order matches the bit layout: sign[31], exp[30:23], frac[22:0].
  typedef struct packed {
    logic                 sign;
    logic [PF_EXP_W-1:0]  exp;
    logic [PF_FRAC_W-1:0] frac;
  } pf_t;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/pf_round.sv
// pf_round -- combinational round-to-nearest-even for a normalised mantissa.
//
// Ports:
//   in_sign   : result sign
//   in_exp    : biased exponent belonging to in_mant
//   in_mant   : 24-bit mantissa with the hidden one at bit 23
//   in_guard  : first bit below the mantissa LSB
//   in_sticky : OR of every bit below the guard bit
//   out_pf    : rounded {sign, exp, frac}
module pf_round
  import pf_pkg::*;
(
  input  logic                in_sign,
  input  logic [PF_EXP_W-1:0] in_exp,
  input  logic [23:0]         in_mant,
  input  logic                in_guard,
  input  logic                in_sticky,
  output pf_t                 out_pf
);

  logic        round_up;
  logic [24:0] mant_sum;

  always_comb begin
    round_up = in_guard & (in_sticky | in_mant[0]);
    mant_sum = {1'b0, in_mant} + {24'b0, round_up};

    out_pf.sign = in_sign;
    // A carry out of the mantissa means it became 1.0 * 2; the fraction
    // is then all zero and the exponent moves up by one.
    if (mant_sum[24]) begin
      out_pf.exp  = in_exp + 8'd1;
      out_pf.frac = '0;
    end else begin
      out_pf.exp  = in_exp;
      out_pf.frac = mant_sum[22:0];
    end
  end

endmodule

// File: rtl/int_to_pf.sv
// int_to_pf -- sequential signed integer to IEEE-754 single converter.
//
// One integer is accepted per transaction (valid/ready). The block takes its
// magnitude, normalises it so that the MSB is set, rounds it to nearest-even
// and holds the float until the consumer takes it.
//
// Parameters:
//   INT_W     : input integer width, 8..32
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   in_valid  : in_int is valid
//   in_ready  : converter is idle and can accept in_int
//   in_int    : signed two's-complement input
//   out_valid : out_pf is valid
//   out_ready : consumer takes out_pf
//   out_pf    : IEEE-754 single result
//   busy      : a conversion is in flight
//
// Build option:
//   INT_TO_PF_FAST_NORM_EN : when defined, NORM uses a leading-zero count
//                            and barrel shift and completes in one cycle.
//                            Otherwise NORM shifts one bit per cycle.
//                            Results are identical in both builds.
module int_to_pf
  import pf_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_int,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pf,
  output logic             busy
);

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [INT_W-1:0]    mag_q, mag_d;
  logic [PF_EXP_W-1:0] exp_q, exp_d;
  logic [31:0]         out_pf_q, out_pf_d;
  logic                out_valid_q, out_valid_d;

  logic [INT_W-1:0]    abs_val;
  logic [INT_W+23:0]   mag_ext;
  logic [23:0]         round_mant;
  logic                round_guard;
  logic                round_sticky;
  pf_t                 round_pf;

`ifdef INT_TO_PF_FAST_NORM_EN
  logic [4:0]          lz_cnt;
`endif

  // The normalised magnitude is right-padded with 24 zeros so the same
  // slices give the mantissa, guard and sticky for every INT_W; for
  // INT_W <= 24 the guard and sticky bits come only from the padding.
  always_comb begin
    mag_ext      = {mag_q, 24'b0};
    round_mant   = mag_ext[INT_W+23 -: 24];
    round_guard  = mag_ext[INT_W-1];
    round_sticky = |mag_ext[INT_W-2:0];
  end

  pf_round u_round (
    .in_sign   (sign_q),
    .in_exp    (exp_q),
    .in_mant   (round_mant),
    .in_guard  (round_guard),
    .in_sticky (round_sticky),
    .out_pf    (round_pf)
  );

  // Two's-complement negate; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    abs_val = mag_q[INT_W-1] ? (~mag_q + 1'b1) : mag_q;
  end

`ifdef INT_TO_PF_FAST_NORM_EN
  // The highest set bit wins because the loop runs upward.
  always_comb begin
    lz_cnt = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (mag_q[i]) lz_cnt = 5'(INT_W - 1 - i);
    end
  end
`endif

  // Next-state and datapath updates. mag_q holds the raw input between
  // acceptance and ABS, then the magnitude being normalised.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    out_pf_d    = out_pf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = in_int;
          state_d = ABS;
        end
      end

      ABS: begin
        sign_d = mag_q[INT_W-1];
        mag_d  = abs_val;
        exp_d  = PF_EXP_W'(PF_BIAS + INT_W - 1);
        // Zero skips normalisation but still passes through ROUND, which
        // turns it into +0 and keeps the zero latency at two cycles.
        state_d = (abs_val == '0) ? ROUND : NORM;
      end

      NORM: begin
`ifdef INT_TO_PF_FAST_NORM_EN
        mag_d   = mag_q << lz_cnt;
        exp_d   = exp_q - PF_EXP_W'(lz_cnt);
        state_d = ROUND;
`else
        if (mag_q[INT_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
`endif
      end

      ROUND: begin
        out_pf_d    = (mag_q == '0) ? 32'h0 : round_pf;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      out_pf_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      out_pf_q    <= out_pf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_pf    = out_pf_q;

endmodule

// File: tb/tb_int_to_pf.sv
// tb_int_to_pf -- directed self-checking bench for int_to_pf (INT_W = 32).
// Expected floats and latencies are hand-computed; latency expectations
// follow the INT_TO_PF_FAST_NORM_EN build option.
module tb_int_to_pf;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInt;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPf;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  int_to_pf #(.INT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_int    (inInt),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_pf    (outPf),
    .busy      (busy)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Nonzero latency is 3 plus the leading-zero count in the serial build.
  function automatic int expLat(input int lz);
`ifdef INT_TO_PF_FAST_NORM_EN
    return 3;
`else
    return 3 + lz;
`endif
  endfunction

  // Waits for in_ready (bounded), presents one integer for the accept edge
  // and waits (bounded) for out_valid, checking latency and result.
  task automatic sendAndWait(input string tag, input logic [31:0] val,
                             input logic [31:0] expPf, input int expCycles);
    int cycles;
    cycles = 0;
    while (!inReady && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_ready"}, {31'b0, inReady}, 32'd1);
    @(negedge clk);
    inValid = 1'b1;
    inInt   = val;
    @(posedge clk); #1;
    inValid = 1'b0;
    cycles  = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!outValid && cycles < 200);
    checkOutput({tag, "_lat"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, "_pf"}, outPf, expPf);
  endtask

  // One DONE handshake, then out_valid must drop, in_ready rise and
  // out_pf keep its value.
  task automatic takeResult(input string tag, input logic [31:0] expPf);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    checkOutput({tag, "_vld0"}, {31'b0, outValid}, 32'd0);
    checkOutput({tag, "_rdy1"}, {31'b0, inReady}, 32'd1);
    checkOutput({tag, "_hold"}, outPf, expPf);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] val,
                               input logic [31:0] expPf, input int expCycles);
    sendAndWait(tag, val, expPf, expCycles);
    takeResult(tag, expPf);
  endtask

  initial begin
    logic [31:0] heldPf;
    rst      = 1'b1;
    inValid  = 1'b0;
    inInt    = '0;
    outReady = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst_busy",  {31'b0, busy},     32'd0);
    checkOutput("rst_pf",    outPf,             32'h0);
    checkOutput("rst_ready", {31'b0, inReady},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'b0, inReady}, 32'd1);

    // Directed conversions: {value, expected float, leading zeros}
    applyStimulus("p100",   32'd100,        32'h42C80000, expLat(25));
    applyStimulus("m305",   -32'sd305,      32'hC3988000, expLat(23));
    applyStimulus("zero",   32'd0,          32'h00000000, 2);
    applyStimulus("one",    32'd1,          32'h3F800000, expLat(31));
    applyStimulus("seven",  32'd7,          32'h40E00000, expLat(29));
    applyStimulus("tie_dn", 32'd16777217,   32'h4B800000, expLat(7));
    applyStimulus("exact",  32'd16777218,   32'h4B800001, expLat(7));
    applyStimulus("tie_up", 32'd16777219,   32'h4B800002, expLat(7));
    applyStimulus("maxpos", 32'h7FFFFFFF,   32'h4F000000, expLat(1));
    applyStimulus("minneg", 32'h80000000,   32'hCF000000, expLat(0));

    // Backpressure: result held for 5 cycles, in_valid pulse ignored
    sendAndWait("bp", 32'd7, 32'h40E00000, expLat(29));
    heldPf = outPf;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      inValid = (i == 2);
      inInt   = 32'd123;
      @(posedge clk); #1;
      checkOutput("bp_valid", {31'b0, outValid}, 32'd1);
      checkOutput("bp_pf",    outPf,             32'h40E00000);
      checkOutput("bp_ready", {31'b0, inReady},  32'd0);
    end
    inValid = 1'b0;
    takeResult("bp", heldPf);
    @(posedge clk); #1;
    checkOutput("bp_not_taken", {31'b0, busy}, 32'd0);

    // Reset during NORM aborts the conversion
    @(negedge clk);
    inValid = 1'b1;
    inInt   = 32'd1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_valid", {31'b0, outValid}, 32'd0);
    checkOutput("abort_busy",  {31'b0, busy},     32'd0);
    checkOutput("abort_ready", {31'b0, inReady},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_rdy1", {31'b0, inReady}, 32'd1);
    applyStimulus("m1", 32'hFFFFFFFF, 32'hBF800000, expLat(31));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
